// File: rtl/decode_scoreboard.sv
// rtl/decode_scoreboard.sv - per-register pending-write scoreboard for decode RAW/WAW stalls
// Optional flush port enabled by defining SCOREBOARD_FLUSH_EN.
module decode_scoreboard #(
  parameter int NR_REGS = 32,
  parameter int CNT_W   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] rs1_i,
  input  logic       rs1_en_i,
  input  logic [4:0] rs2_i,
  input  logic       rs2_en_i,
  input  logic [4:0] rd_i,
  input  logic       rd_we_i,
  input  logic       issue_i,
`ifdef SCOREBOARD_FLUSH_EN
  input  logic       flush_i,
`endif
  input  logic       wb_valid_i,
  input  logic [4:0] wb_rd_i,
  output logic       raw_o,
  output logic [6:0] inflight_o,
  output logic       err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt [NR_REGS];
  logic             flush;
  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
  logic             inc, dec, err;

`ifdef SCOREBOARD_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // x0 and indices beyond NR_REGS read as idle
  function automatic logic [CNT_W-1:0] cnt_of(input logic [4:0] idx);
    logic [CNT_W-1:0] val;
    val = '0;
    for (int r = 1; r < NR_REGS; r++) begin
      if (idx == 5'(r)) val = cnt[r];
    end
    return val;
  endfunction

  always_comb begin
    cnt_rs1 = cnt_of(rs1_i);
    cnt_rs2 = cnt_of(rs2_i);
    cnt_rd  = cnt_of(rd_i);
    cnt_wb  = cnt_of(wb_rd_i);
    raw_o = (rs1_en_i && rs1_i != 5'd0 && cnt_rs1 != '0)
         || (rs2_en_i && rs2_i != 5'd0 && cnt_rs2 != '0)
         || (rd_we_i  && rd_i  != 5'd0 && cnt_rd  == CNT_MAX);
    inc = issue_i && !raw_o && rd_we_i && rd_i != 5'd0;
    dec = wb_valid_i && wb_rd_i != 5'd0 && cnt_wb != '0;
    err = (issue_i && raw_o) || (wb_valid_i && wb_rd_i != 5'd0 && cnt_wb == '0);
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int r = 0; r < NR_REGS; r++) cnt[r] <= '0;
      inflight_o <= 7'd0;
      err_o      <= 1'b0;
    end else begin
      cnt[0] <= '0;
      // a same-register issue and retire cancel out
      for (int r = 1; r < NR_REGS; r++) begin
        if (inc && rd_i == 5'(r) && !(dec && wb_rd_i == 5'(r)))
          cnt[r] <= cnt[r] + 1'b1;
        else if (dec && wb_rd_i == 5'(r) && !(inc && rd_i == 5'(r)))
          cnt[r] <= cnt[r] - 1'b1;
      end
      if (inc && !dec)
        inflight_o <= inflight_o + 7'd1;
      else if (dec && !inc)
        inflight_o <= inflight_o - 7'd1;
      err_o <= err;
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// tb/tb_decode_scoreboard.sv - directed self-checking bench for decode_scoreboard
module tb_decode_scoreboard;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] rs1_i, rs2_i, rd_i, wb_rd_i;
  logic       rs1_en_i, rs2_en_i, rd_we_i, issue_i, wb_valid_i;
`ifdef SCOREBOARD_FLUSH_EN
  logic       flush_i;
`endif
  logic       raw_o, err_o;
  logic [6:0] inflight_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  decode_scoreboard dut (
    .clock      (clock),
    .reset      (reset),
    .rs1_i      (rs1_i),
    .rs1_en_i   (rs1_en_i),
    .rs2_i      (rs2_i),
    .rs2_en_i   (rs2_en_i),
    .rd_i       (rd_i),
    .rd_we_i    (rd_we_i),
    .issue_i    (issue_i),
`ifdef SCOREBOARD_FLUSH_EN
    .flush_i    (flush_i),
`endif
    .wb_valid_i (wb_valid_i),
    .wb_rd_i    (wb_rd_i),
    .raw_o      (raw_o),
    .inflight_o (inflight_o),
    .err_o      (err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rs1_i = 5'd0; rs1_en_i = 1'b0; rs2_i = 5'd0; rs2_en_i = 1'b0;
    rd_i = 5'd0; rd_we_i = 1'b0; issue_i = 1'b0;
    wb_valid_i = 1'b0; wb_rd_i = 5'd0;
`ifdef SCOREBOARD_FLUSH_EN
    flush_i = 1'b0;
`endif
  endtask

  task automatic issue_rd(input logic [4:0] rd);
    rd_i = rd; rd_we_i = 1'b1; issue_i = 1'b1;
    step();
    rd_we_i = 1'b0; issue_i = 1'b0;
  endtask

  task automatic retire(input logic [4:0] rd);
    wb_valid_i = 1'b1; wb_rd_i = rd;
    step();
    wb_valid_i = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    rs1_i = 5'd5; rs1_en_i = 1'b1; #1;
    check("reset_raw", raw_o, 0);
    check("reset_inflight", inflight_o, 0);
    check("reset_err", err_o, 0);

    // writer to x5 then reader of x5, no bypass on writeback
    idle();
    issue_rd(5'd5);
    check("issue5_inflight", inflight_o, 1);
    rs1_i = 5'd5; rs1_en_i = 1'b1; #1;
    check("read5_raw", raw_o, 1);
    wb_valid_i = 1'b1; wb_rd_i = 5'd5; #1;
    check("wb5_same_cycle_raw", raw_o, 1);
    step();
    wb_valid_i = 1'b0; #1;
    check("wb5_next_raw", raw_o, 0);
    check("wb5_inflight", inflight_o, 0);
    check("wb5_err", err_o, 0);

    // saturate x7
    idle();
    issue_rd(5'd7);
    issue_rd(5'd7);
    issue_rd(5'd7);
    check("sat7_inflight", inflight_o, 3);
    rd_i = 5'd7; rd_we_i = 1'b1; #1;
    check("sat7_raw", raw_o, 1);
    issue_i = 1'b1;
    step();
    issue_i = 1'b0; rd_we_i = 1'b0;
    check("sat7_err", err_o, 1);
    check("sat7_no_inc", inflight_o, 3);
    step();
    check("sat7_err_once", err_o, 0);
    retire(5'd7); retire(5'd7); retire(5'd7);
    check("drain7_inflight", inflight_o, 0);
    check("drain7_err", err_o, 0);

    // same-register issue and retire cancel
    issue_rd(5'd9);
    rd_i = 5'd9; rd_we_i = 1'b1; issue_i = 1'b1;
    wb_valid_i = 1'b1; wb_rd_i = 5'd9;
    step();
    idle();
    check("same9_inflight", inflight_o, 1);
    check("same9_err", err_o, 0);
    rs1_i = 5'd9; rs1_en_i = 1'b1; #1;
    check("same9_busy", raw_o, 1);
    idle();
    retire(5'd3);
    check("wb3_idle_err", err_o, 1);
    check("wb3_idle_inflight", inflight_o, 1);
    step();
    check("wb3_err_clears", err_o, 0);

    // issue and retire to different registers
    rd_i = 5'd10; rd_we_i = 1'b1; issue_i = 1'b1;
    wb_valid_i = 1'b1; wb_rd_i = 5'd9;
    step();
    idle();
    check("diff_inflight", inflight_o, 1);
    rs1_i = 5'd9; rs1_en_i = 1'b1; #1;
    check("diff_x9_free", raw_o, 0);
    rs1_en_i = 1'b0; rs2_i = 5'd10; rs2_en_i = 1'b1; #1;
    check("diff_x10_busy", raw_o, 1);

    // x0 everywhere is ignored
    idle();
    rs1_en_i = 1'b1; rd_we_i = 1'b1; issue_i = 1'b1; wb_valid_i = 1'b1; #1;
    check("x0_raw", raw_o, 0);
    step();
    idle();
    check("x0_inflight", inflight_o, 1);
    check("x0_err", err_o, 0);

    issue_rd(5'd2); issue_rd(5'd3); issue_rd(5'd4);
    check("build4_inflight", inflight_o, 4);

`ifdef SCOREBOARD_FLUSH_EN
    flush_i = 1'b1; rd_i = 5'd2; rd_we_i = 1'b1; issue_i = 1'b1;
    step();
    idle();
    check("flush_inflight", inflight_o, 0);
    check("flush_err", err_o, 0);
    rs1_i = 5'd2; rs1_en_i = 1'b1; #1;
    check("flush_x2_free", raw_o, 0);
    idle();
    issue_rd(5'd2); issue_rd(5'd3); issue_rd(5'd4); issue_rd(5'd10);
    check("rebuild4_inflight", inflight_o, 4);
`endif

    reset = 1'b1; rd_i = 5'd2; rd_we_i = 1'b1; issue_i = 1'b1;
    wb_valid_i = 1'b1; wb_rd_i = 5'd3;
    step();
    reset = 1'b0;
    idle();
    check("midreset_inflight", inflight_o, 0);
    check("midreset_err", err_o, 0);
    rs1_i = 5'd2; rs1_en_i = 1'b1; rs2_i = 5'd4; rs2_en_i = 1'b1; #1;
    check("midreset_raw", raw_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decode_scoreboard.md
DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 Parameter NR_REGS, default 32, is the number of architectural integer registers; x0 is included and is never tracked.
REQ-002 Parameter CNT_W, default 2, is the width of each per-register pending-write counter.
REQ-003 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rs1_i / rs2_i  input  5 each  source register indices of the instruction held in decode.
REQ-006 rs1_en_i / rs2_en_i  input  1 each  the instruction reads rs1 / rs2.
REQ-007 rd_i  input  5  destination index; rd_we_i  input  1  the instruction writes rd.
REQ-008 issue_i  input  1  decode-to-execute handshake fired this cycle (valid_post && ready_post).
REQ-009 wb_valid_i  input  1  a register write retires this cycle; wb_rd_i  input  5  its index.
REQ-010 flush_i  input  1  discard all in-flight writes; present only with SCOREBOARD_FLUSH_EN.
REQ-011 raw_o  output  1  hazard: decode SHALL hold its instruction; feeds the decode controller's raw input.
REQ-012 inflight_o  output  7  registered total of pending writes across all registers.
REQ-013 err_o  output  1  registered one-cycle pulse on protocol violation.

Function
REQ-014 Each register r in 1..NR_REGS-1 SHALL own a counter cnt[r] of CNT_W bits; index 0 SHALL never be written or read as busy.
REQ-015 raw_o SHALL be combinational from current counters and inputs: (rs1_en_i && rs1_i!=0 && cnt[rs1_i]!=0) || (rs2_en_i && rs2_i!=0 && cnt[rs2_i]!=0) || (rd_we_i && rd_i!=0 && cnt[rd_i]==max).
REQ-016 Same-cycle writeback SHALL NOT clear raw_o; a retiring write unblocks a reader one cycle later (no bypass).
REQ-017 On issue_i && !raw_o && rd_we_i && rd_i!=0, cnt[rd_i] SHALL increment at the next edge.
REQ-018 On wb_valid_i && wb_rd_i!=0 && cnt[wb_rd_i]!=0, cnt[wb_rd_i] SHALL decrement at the next edge.
REQ-019 Issue and writeback to the same register in one cycle SHALL leave that counter unchanged; to different registers both updates SHALL apply.
REQ-020 issue_i while raw_o=1 SHALL cause no counter change and SHALL pulse err_o the next cycle.
REQ-021 wb_valid_i to a register whose counter is 0 SHALL cause no change and SHALL pulse err_o the next cycle.
REQ-022 A counter SHALL never wrap; REQ-015 saturation stall prevents increment past max (3 at CNT_W=2).
REQ-023 inflight_o SHALL equal the sum of all counters, updated in the same edge as the counters (+1, -1, or net 0).
REQ-024 wb_rd_i=0 and rd_i=0 SHALL be ignored without error.

Reset
REQ-025 While reset=1 at an edge, all counters, inflight_o and err_o SHALL become 0; raw_o then depends only on inputs and SHALL be 0 except via no counters (i.e. 0).
REQ-026 Reset SHALL override issue, writeback and flush in the same cycle; in-flight writes are discarded.

Configuration
REQ-027 With SCOREBOARD_FLUSH_EN defined, flush_i=1 SHALL clear all counters and inflight_o at the next edge, overriding same-cycle issue/writeback, with no err_o.
REQ-028 Without SCOREBOARD_FLUSH_EN, port flush_i SHALL not exist and counters clear only by reset or writeback.

Verification
REQ-029 Reset, then rs1_i=5,rs1_en_i=1 -> raw_o=0, inflight_o=0, err_o=0.
REQ-030 Issue rd=5; next cycle read rs1=5 -> raw_o=1; wb_rd=5 in cycle N -> raw_o still 1 in N, 0 in N+1, inflight_o 1->0.
REQ-031 Issue rd=7 three times -> cnt=3, inflight_o=3; fourth instruction with rd=7 -> raw_o=1; issue_i asserted anyway -> no change, err_o pulses once.
REQ-032 cnt[9]=1, same cycle issue rd=9 and wb_rd=9 -> cnt[9]=1, inflight_o unchanged; wb_rd=3 with cnt[3]=0 -> err_o=1 one cycle.
REQ-033 rs1=0, rd=0 with issue and wb_rd=0 -> raw_o=0, inflight_o unchanged, err_o=0.
REQ-034 With SCOREBOARD_FLUSH_EN: inflight_o=4, flush_i with concurrent issue rd=2 -> all counters 0, inflight_o=0; repeat with reset=1 mid-stream -> same result.
